credit_bcd_tracker: RTL and testbench
=====================================

# credit_bcd_tracker

Parametrised credit accumulator for the vending machine. It accepts coin inserts, vend requests and cancel requests, and holds the running credit in coin units. It produces refund and accept/deny pulses. A sequential shift-add-3 (double-dabble) converter turns the credit into multi-digit BCD cents for the display digit decoders. It sits between the coin/keypad front end and the seven-segment drivers, and replaces fixed lookup conversion of credit to digits.

## Interface
Parameters:
- UNIT_CENTS, 5: cents per credit unit.
- MAX_UNITS, 12: maximum credit in units (60 cents by default). Must satisfy MAX_UNITS < 2^UW.
- UW, 4: width of credit, price and refund unit fields.
- CUW, 3: width of the coin value field.
- DIGITS, 2: number of BCD output digits. Must satisfy MAX_UNITS*UNIT_CENTS < 10^DIGITS.
- Derived CB = clog2(MAX_UNITS*UNIT_CENTS+1): binary width of cents (6 by default).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- coin_valid  in  1  one-cycle coin insert strobe.
- coin_units  in  CUW  value of the inserted coin in units (1 = 5c, 2 = 10c, 5 = 25c).
- vend_req  in  1  one-cycle vend request strobe.
- price_units  in  UW  price of the item, sampled with vend_req.
- cancel  in  1  one-cycle refund request.
- credit_units  out  UW  current credit.
- coin_accept / coin_reject  out  1  one-cycle result pulses.
- vend_ok / vend_deny  out  1  one-cycle result pulses.
- refund_valid  out  1  one-cycle pulse.
- refund_units  out  UW  amount refunded; meaningful only while refund_valid=1, 0 otherwise.
- bcd  out  4*DIGITS  credit in cents; digit 0 (ones) is in bits [3:0].
- bcd_valid  out  1  high when bcd matches credit_units.

## Operation
- Reset (asynchronous, rst_n=0):
  - credit_units=0, bcd=0, bcd_valid=1.
  - All pulses and refund_units are 0. Converter is idle.
  - Any in-flight conversion is discarded.
- Each cycle the events are evaluated in priority order: cancel, then vend, then coin. C below is the registered credit.
- cancel=1:
  - refund_valid=1, refund_units=C, credit becomes 0.
  - A simultaneous vend_req produces no vend_ok and no vend_deny.
  - A simultaneous coin_valid produces coin_reject (the coin is returned).
- vend_req=1 without cancel:
  - If price_units ≤ C: vend_ok=1 and C' = C − price_units. A price of 0 is a valid vend.
  - Otherwise: vend_deny=1 and C' = C.
- coin_valid=1 without cancel:
  - If C' + coin_units ≤ MAX_UNITS: coin_accept=1 and credit = C' + coin_units.
  - Otherwise: coin_reject=1 and credit = C'.
  - A coin_units value of 0 is accepted with no credit change.
- Arithmetic:
  - Unsigned, computed at UW+1 bits before comparison, so coin sums cannot wrap.
  - Credit never exceeds MAX_UNITS and never goes negative.
- Converter FSM states are IDLE and SHIFT.
  - Any edge that changes credit_units loads cents = credit × UNIT_CENTS (CB bits), clears the scratch BCD, enters SHIFT with count=CB, and drops bcd_valid.
  - In SHIFT, each cycle adds 3 to every scratch digit ≥ 5, then shifts left by one, bringing in the binary MSB.
  - When count reaches 0, the FSM copies scratch to bcd, sets bcd_valid=1 and returns to IDLE.
- A credit change during SHIFT restarts the conversion from the new value. bcd holds the last completed value until then.
- An edge with no credit change, such as a denied vend, a rejected coin, or cancel with C=0, does not start a conversion.

## Timing
- Decision pulses, credit_units and refund_units update on the rising edge after the request cycle. Result latency is 1 cycle.
- Pulses are exactly one cycle wide. Back-to-back requests on consecutive cycles are all processed; there is no busy back-pressure on the control path.
- bcd_valid falls on the same edge that updates credit_units. It stays low for exactly CB cycles (6 by default). bcd and bcd_valid update together on the CB-th edge after the load.
- A restart mid-conversion extends the low period to CB cycles after the last credit change.

## Test plan
- Reset and accumulate: assert rst_n=0 mid-conversion, then insert coins 2 and 5 units.
  - After reset: credit 0, bcd=0x00, bcd_valid=1.
  - After the coins: credit 7, and bcd=0x35 six cycles after the last accept.
- Saturation: from credit 10, insert a 5-unit coin → coin_reject, credit stays 10. Then insert a 2-unit coin → coin_accept, credit 12, bcd=0x60.
- Vend: from credit 12, vend with price 7 → vend_ok, credit 5, bcd=0x25. Then vend with price 6 → vend_deny, credit 5, bcd_valid stays 1.
- Simultaneous events:
  - From credit 10, vend with price 5 plus a 5-unit coin in the same cycle → vend_ok, coin_accept, credit 10, no conversion started.
  - From credit 4, cancel plus vend plus a coin in the same cycle → refund 4, coin_reject, no vend pulse, credit 0.
- Restart: insert coins on cycles 0 and 3. bcd_valid stays low until 6 cycles after the second accept, and bcd shows only the final value.
- Parameter variant: UNIT_CENTS=5, MAX_UNITS=40, UW=6, DIGITS=3, so CB=8. Credit 39 gives bcd=0x195 after 8 cycles.

Source files
------------

// File: rtl/credit_bcd_tracker.sv
// Vending credit accumulator: cancel/vend/coin decisions on registered credit,
// plus a sequential double-dabble converter presenting the credit as BCD cents.
module credit_bcd_tracker #(
  parameter int UNIT_CENTS = 5,
  parameter int MAX_UNITS  = 12,
  parameter int UW         = 4,
  parameter int CUW        = 3,
  parameter int DIGITS     = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [CUW-1:0]      coin_units,
  input  logic                vend_req,
  input  logic [UW-1:0]       price_units,
  input  logic                cancel,
  output logic [UW-1:0]       credit_units,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic                vend_ok,
  output logic                vend_deny,
  output logic                refund_valid,
  output logic [UW-1:0]       refund_units,
  output logic [4*DIGITS-1:0] bcd,
  output logic                bcd_valid
);

  localparam int CB   = $clog2(MAX_UNITS * UNIT_CENTS + 1);
  localparam int BW   = 4 * DIGITS;
  localparam int CNTW = $clog2(CB + 1);

  typedef enum logic {IDLE, SHIFT} conv_state_t;

  conv_state_t     state;
  logic [CB-1:0]   bin;
  logic [BW-1:0]   scratch;
  logic [CNTW-1:0] count;

  logic [UW:0]     c_ext, after_vend, coin_sum, c_next_ext;
  logic [UW-1:0]   c_next;
  logic [CB-1:0]   cents;
  logic [BW-1:0]   adj, shifted;
  logic            load;
  logic            n_coin_accept, n_coin_reject, n_vend_ok, n_vend_deny, n_refund_valid;

  // Decision logic; one extra bit keeps coin sums from wrapping before the limit test.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    c_ext          = {1'b0, credit_units};
    after_vend     = c_ext;
    coin_sum       = '0;
    c_next_ext     = c_ext;
    n_coin_accept  = 1'b0;
    n_coin_reject  = 1'b0;
    n_vend_ok      = 1'b0;
    n_vend_deny    = 1'b0;
    n_refund_valid = 1'b0;
    if (cancel) begin
      n_refund_valid = 1'b1;
      n_coin_reject  = coin_valid;
      c_next_ext     = '0;
    end else begin
      if (vend_req) begin
        if ({1'b0, price_units} <= c_ext) begin
          n_vend_ok  = 1'b1;
          after_vend = c_ext - {1'b0, price_units};
        end else begin
          n_vend_deny = 1'b1;
        end
      end
      coin_sum   = after_vend + (UW+1)'(coin_units);
      c_next_ext = after_vend;
      if (coin_valid) begin
        if (coin_sum <= (UW+1)'(MAX_UNITS)) begin
          n_coin_accept = 1'b1;
          c_next_ext    = coin_sum;
        end else begin
          n_coin_reject = 1'b1;
        end
      end
    end
  end

  assign c_next = UW'(c_next_ext);
  assign load   = (c_next != credit_units);
  assign cents  = CB'(c_next * UNIT_CENTS);

  // Add-3 correction on each digit, then shift in the next binary MSB.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    shifted = BW'({adj, bin[CB-1]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_units <= '0;
      coin_accept  <= 1'b0;
      coin_reject  <= 1'b0;
      vend_ok      <= 1'b0;
      vend_deny    <= 1'b0;
      refund_valid <= 1'b0;
      refund_units <= '0;
      bcd          <= '0;
      bcd_valid    <= 1'b1;
      state        <= IDLE;
      bin          <= '0;
      scratch      <= '0;
      count        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      credit_units <= c_next;
      coin_accept  <= n_coin_accept;
      coin_reject  <= n_coin_reject;
      vend_ok      <= n_vend_ok;
      vend_deny    <= n_vend_deny;
      refund_valid <= n_refund_valid;
      refund_units <= n_refund_valid ? credit_units : '0;
      if (load) begin
        // A credit change always (re)starts the conversion; bcd keeps its old value.
        state     <= SHIFT;
        bin       <= cents;
        scratch   <= '0;
        count     <= CNTW'(CB);
        bcd_valid <= 1'b0;
      end else if (state == SHIFT) begin
        scratch <= shifted;
        bin     <= bin << 1;
        count   <= count - 1'b1;
        if (count == CNTW'(1)) begin
          bcd       <= shifted;
          bcd_valid <= 1'b1;
          state     <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_credit_bcd_tracker.sv
// Scoreboard bench for credit_bcd_tracker: a behavioural model predicts each
// cycle's outputs, queues them, and they are compared one cycle later.
module tb_credit_bcd_tracker;

  localparam int CB  = 6;
  localparam int MAX = 12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid, vend_req, cancel;
  logic [2:0] coin_units;
  logic [3:0] price_units;
  logic [3:0] credit_units, refund_units;
  logic       coin_accept, coin_reject, vend_ok, vend_deny, refund_valid;
  logic [7:0] bcd;
  logic       bcd_valid;

  // Wider variant: 40 units max, three digits, CB = 8.
  logic       v_coin_valid;
  logic [2:0] v_coin_units;
  logic [5:0] v_credit_units, v_refund_units;
  logic       v_coin_accept, v_coin_reject, v_vend_ok, v_vend_deny, v_refund_valid;
  logic [11:0] v_bcd;
  logic       v_bcd_valid;

  always #5 clk = ~clk;

  credit_bcd_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_units(coin_units),
    .vend_req(vend_req), .price_units(price_units), .cancel(cancel),
    .credit_units(credit_units),
    .coin_accept(coin_accept), .coin_reject(coin_reject),
    .vend_ok(vend_ok), .vend_deny(vend_deny),
    .refund_valid(refund_valid), .refund_units(refund_units),
    .bcd(bcd), .bcd_valid(bcd_valid)
  );

  credit_bcd_tracker #(.UNIT_CENTS(5), .MAX_UNITS(40), .UW(6), .CUW(3), .DIGITS(3)) dut_wide (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(v_coin_valid), .coin_units(v_coin_units),
    .vend_req(1'b0), .price_units(6'd0), .cancel(1'b0),
    .credit_units(v_credit_units),
    .coin_accept(v_coin_accept), .coin_reject(v_coin_reject),
    .vend_ok(v_vend_ok), .vend_deny(v_vend_deny),
    .refund_valid(v_refund_valid), .refund_units(v_refund_units),
    .bcd(v_bcd), .bcd_valid(v_bcd_valid)
  );

  typedef struct {
    int credit;
    bit ca, cr, vo, vd, rv;
    int ru;
    int bcd;
    bit bv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_credit, m_cnt, m_bcd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int to_bcd(input int cents);
    return ((cents / 100) % 10) * 256 + ((cents / 10) % 10) * 16 + (cents % 10);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    m_credit = 0; m_cnt = 0; m_bcd = 0;
    #3;
    check("rst_credit", credit_units, 0);
    check("rst_bcd", bcd, 8'h00);
    check("rst_bcd_valid", bcd_valid, 1);
    check("rst_pulses", {coin_accept, coin_reject, vend_ok, vend_deny, refund_valid}, 0);
    check("rst_refund", refund_units, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Drive one cycle of stimulus, predict its result, compare after the edge.
  task automatic step(input bit cv, input int cu, input bit vr, input int pu, input bit cn);
    exp_t e;
    int   nc;
    coin_valid = cv; coin_units = 3'(cu);
    vend_req = vr; price_units = 4'(pu); cancel = cn;
    e = '{default: 0};
    nc = m_credit;
    if (cn) begin
      e.rv = 1; e.ru = m_credit; nc = 0; e.cr = cv;
    end else begin
      if (vr) begin
        if (pu <= m_credit) begin e.vo = 1; nc = m_credit - pu; end
        else e.vd = 1;
      end
      if (cv) begin
        if (nc + cu <= MAX) begin e.ca = 1; nc = nc + cu; end
        else e.cr = 1;
      end
    end
    if (nc != m_credit) m_cnt = CB;
    else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_bcd = to_bcd(nc * 5);
    end
    m_credit = nc;
    e.credit = nc; e.bcd = m_bcd; e.bv = (m_cnt == 0);
    q.push_back(e);
    @(posedge clk); #1;
    coin_valid = 0; vend_req = 0; cancel = 0;
    e = q.pop_front();
    check("credit", credit_units, e.credit);
    check("coin_accept", coin_accept, e.ca);
    check("coin_reject", coin_reject, e.cr);
    check("vend_ok", vend_ok, e.vo);
    check("vend_deny", vend_deny, e.vd);
    check("refund_valid", refund_valid, e.rv);
    check("refund_units", refund_units, e.ru);
    check("bcd", bcd, e.bcd);
    check("bcd_valid", bcd_valid, e.bv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    coin_valid = 0; coin_units = 0; vend_req = 0; price_units = 0; cancel = 0;
    v_coin_valid = 0; v_coin_units = 0;
    rst_n = 1'b0;
    #12;
    do_reset();

    // Reset mid-conversion, then accumulate 2 + 5.
    step(1, 3, 0, 0, 0);
    idle(2);
    do_reset();
    step(1, 2, 0, 0, 0);
    step(1, 5, 0, 0, 0);
    idle(CB);
    check("acc_bcd_35", bcd, 8'h35);

    // Saturation at MAX_UNITS.
    step(1, 3, 0, 0, 0);
    idle(CB);
    step(1, 5, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    idle(CB);
    check("sat_bcd_60", bcd, 8'h60);

    // Vend ok, then deny, then a zero-price vend and a zero coin.
    step(0, 0, 1, 7, 0);
    idle(CB);
    check("vend_bcd_25", bcd, 8'h25);
    step(0, 0, 1, 6, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0);

    // Vend and coin together leave credit unchanged.
    step(1, 5, 0, 0, 0);
    idle(CB);
    step(1, 5, 1, 5, 0);
    check("simul_no_conv", bcd_valid, 1);

    // Cancel beats vend and coin.
    step(0, 0, 1, 6, 0);
    idle(CB);
    step(1, 1, 1, 1, 1);
    idle(CB);
    step(0, 0, 0, 0, 1);

    // Restart: coins on cycle 0 and cycle 3.
    step(1, 1, 0, 0, 0);
    idle(2);
    step(1, 2, 0, 0, 0);
    idle(CB);
    check("restart_bcd_15", bcd, 8'h15);

    // Back-to-back strobes with no idle cycles.
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 4, 0);
    step(1, 5, 1, 9, 0);
    step(1, 1, 0, 0, 0);
    idle(CB + 1);

    // Wide variant: 7 x 5 + 4 = 39 units = 195 cents.
    for (int i = 0; i < 8; i++) begin
      v_coin_valid = 1; v_coin_units = (i == 7) ? 3'd4 : 3'd5;
      @(posedge clk); #1;
      v_coin_valid = 0;
      check("wide_accept", v_coin_accept, 1);
    end
    check("wide_credit", v_credit_units, 39);
    repeat (7) @(posedge clk);
    #1;
    check("wide_valid_low", v_bcd_valid, 0);
    @(posedge clk); #1;
    check("wide_valid_high", v_bcd_valid, 1);
    check("wide_bcd_195", v_bcd, 12'h195);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
